// File: rtl/bmb_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the BMB memory arbiter.
//   arb_state_e     : top-level FSM encoding
//   bytes_per_beat  : byte stride of one data beat
//   beat_cnt_width  : counter width that holds the largest read burst length
package bmb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   function automatic int bytes_per_beat(input int data_size);
      return data_size / 8;
   endfunction

   // Largest burst is 2^(2^payload_bits - 1) beats, so 2^payload_bits bits
   // hold the full beat count without wrapping.
   function automatic int beat_cnt_width(input int payload_bits);
      return 2 ** payload_bits;
   endfunction

endpackage

// File: rtl/bmb_mem_arbiter_if.sv
// Bundle of the BMB master ports (per-master unpacked arrays) and the single
// memory request/grant port.
//   slave  : arbiter view (consumes commands, produces responses, drives memory)
//   master : environment view (CPU adapters and memory model)
interface bmb_mem_arbiter_if #(
   parameter int NumReq      = 2,
   parameter int AddrSize    = 32,
   parameter int DataSize    = 64,
   parameter int PayloadBits = 2
) ();
   logic                     req_cmd_valid   [NumReq];
   logic                     req_cmd_ready   [NumReq];
   logic [AddrSize-1:0]      req_cmd_address [NumReq];
   logic [PayloadBits-1:0]   req_cmd_size    [NumReq];
   logic                     req_cmd_wr      [NumReq];
   logic [DataSize-1:0]      req_cmd_data    [NumReq];
   logic [DataSize/8-1:0]    req_cmd_mask    [NumReq];
   logic                     req_cmd_last    [NumReq];
   logic                     rsp_valid       [NumReq];
   logic [DataSize-1:0]      rsp_data        [NumReq];
   logic                     rsp_last        [NumReq];
   logic                     rsp_error       [NumReq];

   logic                     mem_req;
   logic                     mem_gnt;
   logic [AddrSize-1:0]      mem_addr;
   logic [DataSize-1:0]      mem_wdata;
   logic [DataSize/8-1:0]    mem_strb;
   logic                     mem_we;
   logic [DataSize-1:0]      mem_rdata;

   modport slave (
      input  req_cmd_valid, req_cmd_address, req_cmd_size, req_cmd_wr,
             req_cmd_data, req_cmd_mask, req_cmd_last, mem_gnt, mem_rdata,
      output req_cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_error,
             mem_req, mem_addr, mem_wdata, mem_strb, mem_we
   );

   modport master (
      output req_cmd_valid, req_cmd_address, req_cmd_size, req_cmd_wr,
             req_cmd_data, req_cmd_mask, req_cmd_last, mem_gnt, mem_rdata,
      input  req_cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_error,
             mem_req, mem_addr, mem_wdata, mem_strb, mem_we
   );
endinterface

// File: rtl/bmb_rr_arbiter.sv
// Combinational one-hot requester pick.
//   req_i : request vector, one bit per master
//   ptr_i : highest-priority index for this pick
//   gnt_o : one-hot grant (all zero when nothing requests)
// Macro BMB_ARB_FIXED_PRIO_EN: ignore ptr_i, lowest index always wins.
module bmb_rr_arbiter #(
   parameter int NumReq = 2,
   parameter int PtrW   = 1
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [PtrW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o
);

`ifdef BMB_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   always_comb begin
      gnt_o = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (req_i[PtrW'(i)]) begin
            gnt_o        = '0;
            gnt_o[PtrW'(i)] = 1'b1;
         end
      end
   end
`else
   always_comb begin
      int  idx;
      logic found;
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      // Walk from ptr_i upward, wrapping, and take the first requester.
      for (int i = 0; i < NumReq; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!found && req_i[PtrW'(idx)]) begin
            gnt_o[PtrW'(idx)] = 1'b1;
            found             = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/bmb_mem_arbiter.sv
// Transaction-level arbiter sharing one single-ported memory between NumReq
// BMB masters. Sequences burst beat addresses, honours mem_gnt backpressure
// and routes read data back to the owning master.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : BMB command/response arrays plus memory req/gnt port
// Macro BMB_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no rr_ptr.
//
//   state | meaning
//   IDLE  | pick a winner, latch address/size/direction
//   READ  | issue 2^size read beats, ready pulses on first grant
//   WRITE | pass owner's write beats through until last is granted
//   DRAIN | emit final response, advance round-robin pointer
module bmb_mem_arbiter
   import bmb_arb_pkg::*;
#(
   parameter int NumReq      = 2,
   parameter int AddrSize    = 32,
   parameter int DataSize    = 64,
   parameter int PayloadBits = 2
) (
   input logic               clk_i,
   input logic               rst_i,
   bmb_mem_arbiter_if.slave  bus
);
   localparam int BytesPerBeat = bytes_per_beat(DataSize);
   localparam int MaskSize     = DataSize / 8;
   localparam int CntW         = beat_cnt_width(PayloadBits);
   localparam int OwnW         = (NumReq > 1) ? $clog2(NumReq) : 1;

   localparam logic [1:0] StIdle  = IDLE;
   localparam logic [1:0] StRead  = READ;
   localparam logic [1:0] StWrite = WRITE;
   localparam logic [1:0] StDrain = DRAIN;

   logic [1:0]             state_q;
   logic [OwnW-1:0]        owner_q, rr_ptr, gnt_idx;
   logic [AddrSize-1:0]    base_q;
   logic [PayloadBits-1:0] size_q;
   logic                   wr_q;
   logic [CntW-1:0]        beat_q;
   logic                   rsp_pend_q, rsp_last_q;

   logic [NumReq-1:0]      req_vec, gnt_oh;
   logic                   own_valid, own_last, read_last, fire, burst_end;
   logic                   mem_req_d, mem_we_d;
   logic [DataSize-1:0]    wdata_d;
   logic [MaskSize-1:0]    strb_d;
   logic                   ready_d     [NumReq];
   logic                   rsp_valid_d [NumReq];
   logic                   rsp_last_d  [NumReq];
   logic [DataSize-1:0]    rsp_data_d  [NumReq];
   logic                   rsp_err_d   [NumReq];

   always_comb begin
      req_vec = '0;
      gnt_idx = '0;
      for (int i = 0; i < NumReq; i++) begin
         req_vec[i] = bus.req_cmd_valid[i];
         if (gnt_oh[i]) gnt_idx = OwnW'(i);
      end
   end

   bmb_rr_arbiter #(.NumReq(NumReq), .PtrW(OwnW)) u_rr_arbiter (
      .req_i (req_vec),
      .ptr_i (rr_ptr),
      .gnt_o (gnt_oh)
   );

   assign own_valid = bus.req_cmd_valid[owner_q];
   assign own_last  = bus.req_cmd_last[owner_q];
   assign read_last = (beat_q == ((CntW'(1) << size_q) - CntW'(1)));

   always_comb begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      wdata_d   = '0;
      strb_d    = '0;
      for (int i = 0; i < NumReq; i++) ready_d[i] = 1'b0;
      case (state_q)
         StRead: begin
            mem_req_d = 1'b1;
            // Read command is consumed with its first granted beat.
            ready_d[owner_q] = bus.mem_gnt && (beat_q == '0);
         end
         StWrite: begin
            mem_req_d        = own_valid;
            mem_we_d         = own_valid;
            ready_d[owner_q] = bus.mem_gnt;
            if (own_valid) begin
               wdata_d = bus.req_cmd_data[owner_q];
               strb_d  = bus.req_cmd_mask[owner_q];
            end
         end
         default: ;
      endcase
   end

   assign fire      = mem_req_d && bus.mem_gnt;
   assign burst_end = fire && (wr_q ? own_last : read_last);

   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         rsp_valid_d[i] = rsp_pend_q && (owner_q == OwnW'(i));
         rsp_last_d[i]  = rsp_valid_d[i] && rsp_last_q;
         rsp_data_d[i]  = (rsp_valid_d[i] && !wr_q) ? bus.mem_rdata : '0;
         rsp_err_d[i]   = 1'b0;
      end
   end

   assign bus.req_cmd_ready = ready_d;
   assign bus.rsp_valid     = rsp_valid_d;
   assign bus.rsp_last      = rsp_last_d;
   assign bus.rsp_data      = rsp_data_d;
   assign bus.rsp_error     = rsp_err_d;
   assign bus.mem_req       = mem_req_d;
   assign bus.mem_we        = mem_we_d;
   assign bus.mem_wdata     = wdata_d;
   assign bus.mem_strb      = strb_d;
   assign bus.mem_addr      = base_q + AddrSize'(beat_q) * AddrSize'(BytesPerBeat);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         base_q     <= '0;
         size_q     <= '0;
         wr_q       <= 1'b0;
         beat_q     <= '0;
         rsp_pend_q <= 1'b0;
         rsp_last_q <= 1'b0;
      end else begin
         // Reads respond on every beat, writes only once after the last beat.
         rsp_pend_q <= fire && (!wr_q || burst_end);
         rsp_last_q <= burst_end;
         case (state_q)
            StIdle: begin
               if (|req_vec) begin
                  owner_q <= gnt_idx;
                  base_q  <= bus.req_cmd_address[gnt_idx];
                  size_q  <= bus.req_cmd_size[gnt_idx];
                  wr_q    <= bus.req_cmd_wr[gnt_idx];
                  beat_q  <= '0;
                  state_q <= bus.req_cmd_wr[gnt_idx] ? StWrite : StRead;
               end
            end
            StRead, StWrite: begin
               if (fire) beat_q <= beat_q + CntW'(1);
               if (burst_end) state_q <= StDrain;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef BMB_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   // The master that just finished drops to lowest priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (state_q == StDrain) begin
         rr_ptr <= (owner_q == OwnW'(NumReq - 1)) ? '0 : owner_q + OwnW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_bmb_mem_arbiter.sv
module tb_bmb_mem_arbiter;
   localparam int NumReq = 2;

   typedef struct {
      int          master;
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } beat_t;

   typedef struct {
      int          master;
      logic [63:0] data;
      logic        last;
   } rsp_t;

   typedef struct {
      int          master;
      bit          wr;
      logic [31:0] addr;
      logic [1:0]  size;
      int          nbeats;
      bit          gnt_alt;
      logic [31:0] exp_last_addr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gnt_alt = 1'b0;
   logic gnt_ph = 1'b0;
   bit   sb_en = 1'b1;
   logic [31:0] last_gnt_addr = '0;
   int   n_cmp = 0;
   int   n_fail = 0;

   beat_t beat_q [$];
   rsp_t  rsp_q  [$];
   vec_t  vecs [6];

   bmb_mem_arbiter_if #(.NumReq(NumReq), .AddrSize(32), .DataSize(64), .PayloadBits(2)) bus ();

   bmb_mem_arbiter #(.NumReq(NumReq), .AddrSize(32), .DataSize(64), .PayloadBits(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: grant pattern and registered read data.
   always @(posedge clk) gnt_ph <= ~gnt_ph;
   assign bus.mem_gnt = gnt_alt ? gnt_ph : 1'b1;

   function automatic logic [63:0] rdata_of(input logic [31:0] a);
      return {a, a ^ 32'hA5A5_5A5A};
   endfunction

   function automatic logic [63:0] wdata_of(input int m, input int b);
      return {32'hD00D_0000 | 32'(m), 32'h0000_1000 + 32'(b)};
   endfunction

   function automatic logic [7:0] mask_of(input int b);
      return 8'hF0 ^ 8'(b + 1);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_gnt && !bus.mem_we) bus.mem_rdata <= rdata_of(bus.mem_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (sb_en && !rst) begin
         if (bus.mem_req && bus.mem_gnt) begin
            last_gnt_addr = bus.mem_addr;
            if (beat_q.size() == 0) begin
               check("beat_unexpected", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               beat_t e;
               e = beat_q.pop_front();
               check("beat_addr", 64'(bus.mem_addr), 64'(e.addr));
               check("beat_we", 64'(bus.mem_we), 64'(e.we));
               check("beat_wdata", bus.mem_wdata, e.wdata);
               check("beat_strb", 64'(bus.mem_strb), 64'(e.strb));
            end
         end
         for (int m = 0; m < NumReq; m++) begin
            if (bus.rsp_valid[m]) begin
               check("rsp_error", 64'(bus.rsp_error[m]), 64'd0);
               if (rsp_q.size() == 0) begin
                  check("rsp_unexpected", 64'(m), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  rsp_t r;
                  r = rsp_q.pop_front();
                  check("rsp_master", 64'(m), 64'(r.master));
                  check("rsp_data", bus.rsp_data[m], r.data);
                  check("rsp_last", 64'(bus.rsp_last[m]), 64'(r.last));
               end
            end
         end
      end
   end

   task automatic push_read(input int m, input logic [31:0] a, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] ad;
         ad = a + 32'(k * 8);
         beat_q.push_back('{master: m, addr: ad, we: 1'b0, wdata: 64'd0, strb: 8'd0});
         rsp_q.push_back('{master: m, data: rdata_of(ad), last: (k == n - 1)});
      end
   endtask

   task automatic push_write(input int m, input logic [31:0] a, input int n);
      for (int b = 0; b < n; b++)
         beat_q.push_back('{master: m, addr: a + 32'(b * 8), we: 1'b1,
                            wdata: wdata_of(m, b), strb: mask_of(b)});
      rsp_q.push_back('{master: m, data: 64'd0, last: 1'b1});
   endtask

   task automatic drive_read(input int m, input logic [31:0] a, input logic [1:0] sz);
      bit ok;
      ok = 1'b0;
      bus.req_cmd_valid[m]   = 1'b1;
      bus.req_cmd_address[m] = a;
      bus.req_cmd_size[m]    = sz;
      bus.req_cmd_wr[m]      = 1'b0;
      bus.req_cmd_last[m]    = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (bus.req_cmd_ready[m]) begin
            ok = 1'b1;
            break;
         end
      end
      check("rd_accept", 64'(ok), 64'd1);
      tick();
      bus.req_cmd_valid[m] = 1'b0;
   endtask

   task automatic drive_write(input int m, input logic [31:0] a, input int n, input int drop_at);
      for (int b = 0; b < n; b++) begin
         bit ok;
         if (b == drop_at) begin
            bus.req_cmd_valid[m] = 1'b0;
            for (int d = 0; d < 2; d++) begin
               @(negedge clk);
               check("drop_mem_req", 64'(bus.mem_req), 64'd0);
               tick();
            end
         end
         ok = 1'b0;
         bus.req_cmd_valid[m]   = 1'b1;
         bus.req_cmd_address[m] = a;
         bus.req_cmd_size[m]    = 2'd0;
         bus.req_cmd_wr[m]      = 1'b1;
         bus.req_cmd_data[m]    = wdata_of(m, b);
         bus.req_cmd_mask[m]    = mask_of(b);
         bus.req_cmd_last[m]    = (b == n - 1);
         for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.mem_we) check("wr_ready_mirror", 64'(bus.req_cmd_ready[m]), 64'(bus.mem_gnt));
            if (bus.req_cmd_ready[m]) begin
               ok = 1'b1;
               break;
            end
         end
         check("wr_accept", 64'(ok), 64'd1);
         tick();
      end
      bus.req_cmd_valid[m] = 1'b0;
      bus.req_cmd_last[m]  = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (beat_q.size() == 0 && rsp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("sb_drained", 64'(ok), 64'd1);
      tick();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int m = 0; m < NumReq; m++) begin
         bus.req_cmd_valid[m]   = 1'b0;
         bus.req_cmd_address[m] = '0;
         bus.req_cmd_size[m]    = '0;
         bus.req_cmd_wr[m]      = 1'b0;
         bus.req_cmd_data[m]    = '0;
         bus.req_cmd_mask[m]    = '0;
         bus.req_cmd_last[m]    = 1'b0;
      end
      bus.mem_rdata = '0;

      //          master wr    addr          size  beats alt   last addr
      vecs[0] = '{0, 1'b0, 32'h0000_1000, 2'd2, 4, 1'b0, 32'h0000_1018};
      vecs[1] = '{1, 1'b1, 32'h0000_2000, 2'd0, 3, 1'b1, 32'h0000_2010};
      vecs[2] = '{0, 1'b0, 32'h0000_0040, 2'd0, 1, 1'b1, 32'h0000_0040};
      vecs[3] = '{1, 1'b0, 32'h0000_0100, 2'd3, 8, 1'b1, 32'h0000_0138};
      vecs[4] = '{0, 1'b0, 32'hFFFF_FFF8, 2'd1, 2, 1'b0, 32'h0000_0000};
      vecs[5] = '{0, 1'b1, 32'h0000_0500, 2'd0, 1, 1'b0, 32'h0000_0500};

      apply_reset();
      @(negedge clk);
      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_wdata", bus.mem_wdata, 64'd0);
      check("rst_mem_strb", 64'(bus.mem_strb), 64'd0);
      for (int m = 0; m < NumReq; m++) begin
         check("rst_ready", 64'(bus.req_cmd_ready[m]), 64'd0);
         check("rst_rsp_valid", 64'(bus.rsp_valid[m]), 64'd0);
         check("rst_rsp_last", 64'(bus.rsp_last[m]), 64'd0);
         check("rst_rsp_data", bus.rsp_data[m], 64'd0);
      end
      tick();

      // Arbitration latency: request at cycle 0, mem_req at 1, response at 2.
      push_read(0, 32'h0000_1000, 4);
      bus.req_cmd_valid[0]   = 1'b1;
      bus.req_cmd_address[0] = 32'h0000_1000;
      bus.req_cmd_size[0]    = 2'd2;
      bus.req_cmd_wr[0]      = 1'b0;
      @(negedge clk);
      check("lat_c0_mem_req", 64'(bus.mem_req), 64'd0);
      check("lat_c0_ready", 64'(bus.req_cmd_ready[0]), 64'd0);
      tick();
      @(negedge clk);
      check("lat_c1_mem_req", 64'(bus.mem_req), 64'd1);
      check("lat_c1_addr", 64'(bus.mem_addr), 64'h1000);
      check("lat_c1_ready", 64'(bus.req_cmd_ready[0]), 64'd1);
      tick();
      bus.req_cmd_valid[0] = 1'b0;
      @(negedge clk);
      check("lat_c2_rsp_valid", 64'(bus.rsp_valid[0]), 64'd1);
      check("lat_c2_ready", 64'(bus.req_cmd_ready[0]), 64'd0);
      wait_done();

      // Simultaneous requests right after reset.
      apply_reset();
      push_read(0, 32'h0000_3000, 1);
      push_read(1, 32'h0000_4000, 1);
      fork
         drive_read(0, 32'h0000_3000, 2'd0);
         drive_read(1, 32'h0000_4000, 2'd0);
      join
      wait_done();

      // Master 0 alone, then both together: master 0 has just finished.
      push_read(0, 32'h0000_3100, 1);
      drive_read(0, 32'h0000_3100, 2'd0);
      wait_done();
`ifdef BMB_ARB_FIXED_PRIO_EN
      push_read(0, 32'h0000_3200, 1);
      push_read(1, 32'h0000_4200, 1);
`else
      push_read(1, 32'h0000_4200, 1);
      push_read(0, 32'h0000_3200, 1);
`endif
      fork
         drive_read(0, 32'h0000_3200, 2'd0);
         drive_read(1, 32'h0000_4200, 2'd0);
      join
      wait_done();

      for (int i = 0; i < 6; i++) begin
         gnt_alt = vecs[i].gnt_alt;
         if (vecs[i].wr) begin
            push_write(vecs[i].master, vecs[i].addr, vecs[i].nbeats);
            drive_write(vecs[i].master, vecs[i].addr, vecs[i].nbeats, -1);
         end else begin
            push_read(vecs[i].master, vecs[i].addr, vecs[i].nbeats);
            drive_read(vecs[i].master, vecs[i].addr, vecs[i].size);
         end
         wait_done();
         check("vec_last_addr", 64'(last_gnt_addr), 64'(vecs[i].exp_last_addr));
      end
      gnt_alt = 1'b0;

      // Write owner pauses mid-burst while master 1 waits for the bus.
      push_write(0, 32'h0000_6000, 3);
      push_read(1, 32'h0000_7000, 1);
      fork
         drive_write(0, 32'h0000_6000, 3, 1);
         begin
            repeat (3) tick();
            drive_read(1, 32'h0000_7000, 2'd0);
         end
      join
      wait_done();

      // Reset during beat 2 of a 4-beat read.
      sb_en = 1'b0;
      bus.req_cmd_valid[0]   = 1'b1;
      bus.req_cmd_address[0] = 32'h0000_3000;
      bus.req_cmd_size[0]    = 2'd2;
      bus.req_cmd_wr[0]      = 1'b0;
      tick();
      @(negedge clk);
      check("rstb_beat0_addr", 64'(bus.mem_addr), 64'h3000);
      tick();
      bus.req_cmd_valid[0] = 1'b0;
      tick();
      @(negedge clk);
      check("rstb_beat2_addr", 64'(bus.mem_addr), 64'h3010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstb_mem_req", 64'(bus.mem_req), 64'd0);
      check("rstb_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rstb_ready0", 64'(bus.req_cmd_ready[0]), 64'd0);
      for (int k = 0; k < 6; k++) begin
         check("rstb_no_rsp", 64'(bus.rsp_valid[0] | bus.rsp_valid[1]), 64'd0);
         @(negedge clk);
      end
      tick();
      sb_en = 1'b1;
      push_read(1, 32'h0000_8000, 4);
      drive_read(1, 32'h0000_8000, 2'd2);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
